// File: rtl/dpd_pkg.sv
// Shared types for the serial BCD-to-declet sequencer.
// One group is three BCD digits; one declet is its 10-bit binary value.
package dpd_pkg;

    typedef logic [11:0] bcd3_t;
    typedef logic [9:0] declet_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DECLET_MAX = 999;

endpackage

// File: rtl/dpd_encode_seq_if.sv
// Valid/ready bundle between the BCD formatter, the sequencer and the declet packer.
// The master side feeds words and takes results; the slave side is the sequencer.
interface dpd_encode_seq_if #(
    parameter int N = 11
);

    logic            in_valid;
    logic            in_ready;
    logic [N*12-1:0] i;
    logic            out_valid;
    logic            out_ready;
    logic [N*10-1:0] o;
    logic            err;
    logic            busy;

    modport master(
        output in_valid,
        output i,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  o,
        input  err,
        input  busy
    );

    modport slave(
        input  in_valid,
        input  i,
        input  out_ready,
        output in_ready,
        output out_valid,
        output o,
        output err,
        output busy
    );

endinterface

// File: rtl/dpd_group_enc.sv
// Combinational 3-digit BCD group to binary declet encoder.
// Digits above 9 still encode (result wraps at 10 bits) and raise invalid.
module dpd_group_enc
    import dpd_pkg::*;
(
    input  bcd3_t   d,
    output declet_t q,
    output logic    invalid
);

    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;

    assign d0 = d[3:0];
    assign d1 = d[7:4];
    assign d2 = d[11:8];

    // Modulo-1024 arithmetic gives the same low bits as the 11-bit sum.
    assign q = 10'(d0)
             + 10'(d1) * 10'd10
             + 10'(d2) * 10'd100;

    assign invalid = (d0 > 4'd9)
                   | (d1 > 4'd9)
                   | (d2 > 4'd9);

endmodule

// File: rtl/dpd_encode_seq.sv
// Serial BCD significand to declet converter: one shared group encoder,
// one group per clock, least significant group first.
module dpd_encode_seq
    import dpd_pkg::*;
#(
    parameter int  N    = 11,
    localparam int CNTW = $clog2(N + 1)
) (
    input logic            clk,
    input logic            rst,
    dpd_encode_seq_if.slave bus
);

    state_t            state_q;
    state_t            state_d;
    logic [CNTW-1:0]   cnt_q;
    logic [CNTW-1:0]   cnt_d;
    bcd3_t   [N-1:0]   src_q;
    bcd3_t   [N-1:0]   src_d;
    declet_t [N-1:0]   o_q;
    declet_t [N-1:0]   o_d;
    logic              err_q;
    logic              err_d;

    bcd3_t             grp;
    declet_t           enc;
    logic              inv;

    always_comb begin
        grp = '0;
        for (int g = 0; g < N; g++) begin
            if (cnt_q == CNTW'(g)) begin
                grp = src_q[g];
            end
        end
    end

    dpd_group_enc u_enc (
        .d      (grp),
        .q      (enc),
        .invalid(inv)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        o_d     = o_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    src_d   = bus.i;
                    o_d     = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int g = 0; g < N; g++) begin
                    if (cnt_q == CNTW'(g)) begin
                        o_d[g] = enc;
                    end
                end
                err_d = err_q | inv;
                if (cnt_q == CNTW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset drops any word in flight; no partial result is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            o_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            o_q     <= o_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.o         = o_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_dpd_encode_seq.sv
// Bench for dpd_encode_seq at N=2, N=4 and N=11 with a reference model.
// Expected words are queued at acceptance and compared at output handshake.
module tb_dpd_encode_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst2;
    logic rst4;
    logic rst11;

    dpd_encode_seq_if #(.N(2))  b2 ();
    dpd_encode_seq_if #(.N(4))  b4 ();
    dpd_encode_seq_if #(.N(11)) b11 ();

    dpd_encode_seq #(.N(2)) u2 (
        .clk(clk),
        .rst(rst2),
        .bus(b2.slave)
    );

    dpd_encode_seq #(.N(4)) u4 (
        .clk(clk),
        .rst(rst4),
        .bus(b4.slave)
    );

    dpd_encode_seq #(.N(11)) u11 (
        .clk(clk),
        .rst(rst11),
        .bus(b11.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [110:0] sb2[$];
    logic [110:0] sb11[$];

    // bit 110 = err, bits [n*10-1:0] = declets
    function automatic logic [110:0] model(input logic [131:0] w, input int n);
        logic [110:0] r;
        int s;
        logic [3:0] a, b, c;
        r = '0;
        for (int g = 0; g < n; g++) begin
            a = w[g*12+:4];
            b = w[g*12+4+:4];
            c = w[g*12+8+:4];
            s = int'(a) + 10 * int'(b) + 100 * int'(c);
            r[g*10+:10] = s[9:0];
            if (a > 9 || b > 9 || c > 9) r[110] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [3:0] rdig();
        if ($urandom_range(0, 9) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst2 = 1'b1;
        b2.in_valid = 1'b1;
        tick();
        rst2 = 1'b0;
        b2.in_valid = 1'b0;
        checks++;
        if (b2.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", b2.in_ready);
        end
        checks++;
        if (b2.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", b2.out_valid);
        end
        checks++;
        if (b2.o !== 20'd0 || b2.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_o_err: got o=%h err=%b want 0/0", b2.o, b2.err);
        end
        checks++;
        if (b2.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", b2.busy);
        end
    endtask

    task automatic test_basic();
        b2.i = {12'h999, 12'h123};
        b2.in_valid = 1'b1;
        b2.out_ready = 1'b1;
        tick();
        b2.in_valid = 1'b0;
        checks++;
        if (b2.busy !== 1'b1 || b2.in_ready !== 1'b0 || b2.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_run0: busy=%b in_ready=%b out_valid=%b want 1/0/0",
                     b2.busy, b2.in_ready, b2.out_valid);
        end
        tick();
        checks++;
        if (b2.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: out_valid=%b want 0", b2.out_valid);
        end
        tick();
        checks++;
        if (b2.out_valid !== 1'b1 || b2.o !== {10'd999, 10'd123} || b2.err !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: v=%b o=%h err=%b want 1/%h/0",
                     b2.out_valid, b2.o, b2.err, {10'd999, 10'd123});
        end
        tick();
        checks++;
        if (b2.busy !== 1'b0 || b2.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: busy=%b out_valid=%b want 0/0", b2.busy, b2.out_valid);
        end
        b2.out_ready = 1'b0;
    endtask

    task automatic test_invalid();
        b2.i = {12'h000, 12'hFFF};
        b2.in_valid = 1'b1;
        tick();
        b2.in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (b2.out_valid !== 1'b1 || b2.o !== {10'd0, 10'd641} || b2.err !== 1'b1) begin
            errors++;
            $display("FAIL invalid_result: v=%b o=%h err=%b want 1/%h/1",
                     b2.out_valid, b2.o, b2.err, {10'd0, 10'd641});
        end
        b2.out_ready = 1'b1;
        tick();
        b2.out_ready = 1'b0;
        b2.i = {12'h456, 12'h789};
        b2.in_valid = 1'b1;
        tick();
        b2.in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (b2.out_valid !== 1'b1 || b2.o !== {10'd456, 10'd789} || b2.err !== 1'b0) begin
            errors++;
            $display("FAIL invalid_clear: v=%b o=%h err=%b want 1/%h/0",
                     b2.out_valid, b2.o, b2.err, {10'd456, 10'd789});
        end
        b2.out_ready = 1'b1;
        tick();
        b2.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic stable;
        b2.out_ready = 1'b0;
        b2.i = {12'h321, 12'h050};
        b2.in_valid = 1'b1;
        tick();
        b2.in_valid = 1'b0;
        tick();
        tick();
        b2.i = {12'h777, 12'h888};
        b2.in_valid = 1'b1;
        stable = 1'b1;
        repeat (20) begin
            if (!(b2.out_valid === 1'b1 && b2.in_ready === 1'b0 &&
                  b2.o === {10'd321, 10'd50} && b2.err === 1'b0))
                stable = 1'b0;
            tick();
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got o=%h v=%b rdy=%b want stable %h/1/0",
                     b2.o, b2.out_valid, b2.in_ready, {10'd321, 10'd50});
        end
        b2.out_ready = 1'b1;
        tick();
        b2.out_ready = 1'b0;
        checks++;
        if (b2.out_valid !== 1'b0 || b2.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: v=%b rdy=%b want 0/1", b2.out_valid, b2.in_ready);
        end
        tick();
        b2.in_valid = 1'b0;
        checks++;
        if (b2.busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: busy=%b want 1", b2.busy);
        end
        tick();
        tick();
        checks++;
        if (b2.out_valid !== 1'b1 || b2.o !== {10'd777, 10'd888}) begin
            errors++;
            $display("FAIL bp_next: v=%b o=%h want 1/%h", b2.out_valid, b2.o, {10'd777, 10'd888});
        end
        b2.out_ready = 1'b1;
        tick();
        b2.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [131:0] w;
        logic [110:0] e;
        b4.i = {12'h111, 12'h222, 12'h333, 12'h444};
        b4.in_valid = 1'b1;
        tick();
        b4.in_valid = 1'b0;
        tick();
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        checks++;
        if (b4.out_valid !== 1'b0 || b4.o !== 40'd0 || b4.in_ready !== 1'b1 || b4.busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: v=%b o=%h rdy=%b busy=%b want 0/0/1/0",
                     b4.out_valid, b4.o, b4.in_ready, b4.busy);
        end
        w = '0;
        w[47:0] = {12'h987, 12'h654, 12'h321, 12'h090};
        e = model(w, 4);
        b4.i = w[47:0];
        b4.in_valid = 1'b1;
        b4.out_ready = 1'b1;
        tick();
        b4.in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (b4.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_early: out_valid=%b want 0", b4.out_valid);
        end
        tick();
        checks++;
        if (b4.out_valid !== 1'b1 || b4.o !== e[39:0] || b4.err !== e[110]) begin
            errors++;
            $display("FAIL midrst_result: v=%b o=%h err=%b want 1/%h/%b",
                     b4.out_valid, b4.o, b4.err, e[39:0], e[110]);
        end
        tick();
        checks++;
        if (b4.busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: busy=%b want 0", b4.busy);
        end
        b4.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int na;
        int outs;
        int acc_cyc[2];
        logic acc;
        logic fire;
        logic [131:0] w;
        logic [110:0] e;
        na = 0;
        outs = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        b11.i = '0;
        b11.in_valid = 1'b1;
        b11.out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && outs < 2; cyc++) begin
            acc = b11.in_valid && b11.in_ready;
            fire = b11.out_valid && b11.out_ready;
            if (acc) begin
                w = b11.i;
                sb11.push_back(model(w, 11));
                if (na < 2) acc_cyc[na] = cyc;
                na++;
            end
            if (fire) begin
                outs++;
                checks++;
                if (sb11.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got o=%h want no output", b11.o);
                end else begin
                    e = sb11.pop_front();
                    if (b11.o !== e[109:0] || b11.err !== e[110]) begin
                        errors++;
                        $display("FAIL b2b_word: got o=%h err=%b want %h/%b",
                                 b11.o, b11.err, e[109:0], e[110]);
                    end
                end
            end
            tick();
            if (acc && na == 1) b11.i = {11{12'h999}};
            if (acc && na == 2) b11.in_valid = 1'b0;
        end
        b11.in_valid = 1'b0;
        checks++;
        if (outs != 2 || na != 2) begin
            errors++;
            $display("FAIL b2b_count: got outs=%0d acc=%0d want 2/2", outs, na);
        end
        checks++;
        if (acc_cyc[1] - acc_cyc[0] < 13) begin
            errors++;
            $display("FAIL b2b_interval: got %0d want >=13", acc_cyc[1] - acc_cyc[0]);
        end
        checks++;
        if (b11.o !== {11{10'd999}}) begin
            errors++;
            $display("FAIL b2b_last: got o=%h want all 999", b11.o);
        end
    endtask

    task automatic test_random();
        int sent;
        int got;
        logic acc;
        logic fire;
        logic [131:0] w;
        logic [110:0] e;
        sent = 0;
        got = 0;
        b2.in_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && got < 30; cyc++) begin
            if (!b2.in_valid && sent < 30 && $urandom_range(0, 1) == 1) begin
                b2.i = {rdig(), rdig(), rdig(), rdig(), rdig(), rdig()};
                b2.in_valid = 1'b1;
            end
            b2.out_ready = 1'($urandom_range(0, 1));
            acc = b2.in_valid && b2.in_ready;
            fire = b2.out_valid && b2.out_ready;
            if (acc) begin
                w = '0;
                w[23:0] = b2.i;
                sb2.push_back(model(w, 2));
                sent++;
            end
            if (fire) begin
                got++;
                checks++;
                if (sb2.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: got o=%h want no output", b2.o);
                end else begin
                    e = sb2.pop_front();
                    if (b2.o !== e[19:0] || b2.err !== e[110]) begin
                        errors++;
                        $display("FAIL rand_word: got o=%h err=%b want %h/%b",
                                 b2.o, b2.err, e[19:0], e[110]);
                    end
                end
            end
            tick();
            if (acc) b2.in_valid = 1'b0;
        end
        b2.in_valid = 1'b0;
        b2.out_ready = 1'b0;
        checks++;
        if (got != 30 || sb2.size() != 0) begin
            errors++;
            $display("FAIL rand_count: got %0d outputs, %0d pending want 30/0", got, sb2.size());
        end
    endtask

    initial begin
        rst2 = 1'b1;
        rst4 = 1'b1;
        rst11 = 1'b1;
        b2.in_valid = 1'b0;
        b2.out_ready = 1'b0;
        b2.i = '0;
        b4.in_valid = 1'b0;
        b4.out_ready = 1'b0;
        b4.i = '0;
        b11.in_valid = 1'b0;
        b11.out_ready = 1'b0;
        b11.i = '0;
        tick();
        tick();
        rst2 = 1'b0;
        rst4 = 1'b0;
        rst11 = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_invalid();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
